// File: rtl/muldiv_unit_pkg.sv
// Shared opcode encodings, FSM state constants and opcode decode helpers for muldiv_unit.
package muldiv_unit_pkg;

  localparam logic [5:0] OPT_MUL    = 6'h20;
  localparam logic [5:0] OPT_MULH   = 6'h21;
  localparam logic [5:0] OPT_MULHSU = 6'h22;
  localparam logic [5:0] OPT_MULHU  = 6'h23;
  localparam logic [5:0] OPT_DIV    = 6'h24;
  localparam logic [5:0] OPT_DIVU   = 6'h25;
  localparam logic [5:0] OPT_REM    = 6'h26;
  localparam logic [5:0] OPT_REMU   = 6'h27;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic opt_is_mul(input logic [5:0] opt);
    return (opt == OPT_MUL) || (opt == OPT_MULH) || (opt == OPT_MULHSU) || (opt == OPT_MULHU);
  endfunction

  function automatic logic opt_is_div(input logic [5:0] opt);
    return (opt == OPT_DIV) || (opt == OPT_DIVU) || (opt == OPT_REM) || (opt == OPT_REMU);
  endfunction

  function automatic logic opt_is_rem(input logic [5:0] opt);
    return (opt == OPT_REM) || (opt == OPT_REMU);
  endfunction

  function automatic logic opt_is_high(input logic [5:0] opt);
    return (opt == OPT_MULH) || (opt == OPT_MULHSU) || (opt == OPT_MULHU);
  endfunction

  // MULHSU treats rs1 as signed and rs2 as unsigned.
  function automatic logic opt_rs1_signed(input logic [5:0] opt);
    return (opt == OPT_MUL) || (opt == OPT_MULH) || (opt == OPT_MULHSU) ||
           (opt == OPT_DIV) || (opt == OPT_REM);
  endfunction

  function automatic logic opt_rs2_signed(input logic [5:0] opt);
    return (opt == OPT_MUL) || (opt == OPT_MULH) || (opt == OPT_DIV) || (opt == OPT_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Two-lane conditional two's-complement negation: operand magnitudes on entry, result signs on exit.
module muldiv_sign_adjust #(
  parameter int WA = 32,
  parameter int WB = 32
) (
  input  logic [WA-1:0] i_a,
  input  logic          i_neg_a,
  input  logic [WB-1:0] i_b,
  input  logic          i_neg_b,
  output logic [WA-1:0] o_a,
  output logic [WB-1:0] o_b
);

  assign o_a = i_neg_a ? (~i_a + WA'(1)) : i_a;
  assign o_b = i_neg_b ? (~i_b + WB'(1)) : i_b;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with a result-hold handshake toward the CDB.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; otherwise multiplies are shift-add.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OPT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPT_W-1:0] in_opt,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [ROB_W-1:0] in_rob_index,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_res,
  output logic [ROB_W-1:0] out_rob_index,
  input  logic             out_ack
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [XLEN-1:0]   r_res;
  logic [ROB_W-1:0]  r_rob;
  logic [OPT_W-1:0]  r_opt;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_accept;
  logic              w_rs1_neg;
  logic              w_rs2_neg;
  logic [XLEN-1:0]   w_rs1_abs;
  logic [XLEN-1:0]   w_rs2_abs;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_special_res;
  logic              w_last;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_sh;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_adj_a_in;
  logic [2*XLEN-1:0] w_adj_a;
  logic [XLEN-1:0]   w_adj_b;
  logic [XLEN-1:0]   w_fix_res;

  assign in_ready      = (r_state == ST_IDLE) && rdy_in && rst_n_in;
  assign w_accept      = in_valid && in_ready && !flush_in;
  assign out_valid     = r_valid;
  assign out_res       = r_res;
  assign out_rob_index = r_rob;

  assign w_rs1_neg = opt_rs1_signed(in_opt) && in_rs1[XLEN-1];
  assign w_rs2_neg = opt_rs2_signed(in_opt) && in_rs2[XLEN-1];

  muldiv_sign_adjust #(.WA(XLEN), .WB(XLEN)) u_operand_abs (
    .i_a     (in_rs1),
    .i_neg_a (w_rs1_neg),
    .i_b     (in_rs2),
    .i_neg_b (w_rs2_neg),
    .o_a     (w_rs1_abs),
    .o_b     (w_rs2_abs)
  );

  assign w_div0 = (in_rs2 == '0);
  assign w_ovf  = ((in_opt == OPT_DIV) || (in_opt == OPT_REM)) &&
                  (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);

  always_comb begin
    w_special_res = '0;
    if (opt_is_rem(in_opt)) w_special_res = w_div0 ? in_rs1 : '0;
    else                    w_special_res = w_div0 ? '1 : in_rs1;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_fm_a;
  logic signed [XLEN:0]     w_fm_b;
  logic signed [2*XLEN+1:0] w_fm_p;
  logic [XLEN-1:0]          w_fm_res;

  assign w_fm_a   = {opt_rs1_signed(in_opt) & in_rs1[XLEN-1], in_rs1};
  assign w_fm_b   = {opt_rs2_signed(in_opt) & in_rs2[XLEN-1], in_rs2};
  assign w_fm_p   = w_fm_a * w_fm_b;
  assign w_fm_res = opt_is_high(in_opt) ? w_fm_p[2*XLEN-1:XLEN] : w_fm_p[XLEN-1:0];
`endif

  assign w_last = (r_cnt == CNT_W'(XLEN));

  // Shift-add: high half accumulates, low half shifts the multiplier out LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring division: high half is the partial remainder, low half shifts quotient bits in.
  assign w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_next = w_div_diff[XLEN] ? {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_adj_a_in = (r_state == ST_DIV) ? {{XLEN{1'b0}}, r_acc[XLEN-1:0]} : r_acc;

  muldiv_sign_adjust #(.WA(2*XLEN), .WB(XLEN)) u_result_sign (
    .i_a     (w_adj_a_in),
    .i_neg_a (r_neg_q),
    .i_b     (r_acc[2*XLEN-1:XLEN]),
    .i_neg_b (r_neg_r),
    .o_a     (w_adj_a),
    .o_b     (w_adj_b)
  );

  always_comb begin
    w_fix_res = w_adj_a[XLEN-1:0];
    if (opt_is_rem(r_opt))       w_fix_res = w_adj_b;
    else if (opt_is_high(r_opt)) w_fix_res = w_adj_a[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_res   <= '0;
      r_rob   <= '0;
    end else if (flush_in) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end else if (rdy_in) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_rob <= in_rob_index;
            if (opt_is_mul(in_opt)) begin
`ifdef MULDIV_FAST_MUL_EN
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_res   <= w_fm_res;
`else
              r_state <= ST_MUL;
`endif
            end else if (opt_is_div(in_opt)) begin
              if (w_div0 || w_ovf) begin
                r_state <= ST_DONE;
                r_valid <= 1'b1;
                r_res   <= w_special_res;
              end else begin
                r_state <= ST_DIV;
              end
            end else begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_res   <= '0;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_res   <= w_fix_res;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (out_ack) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_opt   <= in_opt;
      r_b     <= w_rs2_abs;
      r_acc   <= {{XLEN{1'b0}}, w_rs1_abs};
      r_neg_q <= w_rs1_neg ^ w_rs2_neg;
      r_neg_r <= w_rs1_neg;
    end else if (rdy_in && !flush_in && !w_last) begin
      if (r_state == ST_MUL)      r_acc <= w_mul_next;
      else if (r_state == ST_DIV) r_acc <= w_div_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency, hold, stall, flush and reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int OPT_W = 6;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             rdy_in;
  logic             flush_in;
  logic             in_valid;
  logic             in_ready;
  logic [OPT_W-1:0] in_opt;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [ROB_W-1:0] in_rob_index;
  logic             out_valid;
  logic [XLEN-1:0]  out_res;
  logic [ROB_W-1:0] out_rob_index;
  logic             out_ack;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .OPT_W(OPT_W)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opt        (in_opt),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rob_index  (in_rob_index),
    .out_valid     (out_valid),
    .out_res       (out_res),
    .out_rob_index (out_rob_index),
    .out_ack       (out_ack)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] opt, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] rob, input logic [31:0] exp,
                        input int exp_lat, input int stall_at, input int hold);
    int lat;
    @(negedge clk_in);
    check({tag, "/ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_opt = opt; in_rs1 = a; in_rs2 = b; in_rob_index = rob;
    @(posedge clk_in);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      lat++;
      if (stall_at != 0 && lat == stall_at) rdy_in = 1'b0;
      if (stall_at != 0 && lat == stall_at + 3) rdy_in = 1'b1;
    end while (!out_valid && lat < 200);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/res"}, out_res, exp);
    check({tag, "/rob"}, 32'(out_rob_index), 32'(rob));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_in);
      #1;
      check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/hold_res"}, out_res, exp);
      check({tag, "/hold_rob"}, 32'(out_rob_index), 32'(rob));
      check({tag, "/hold_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk_in);
    out_ack = 1'b1;
    @(posedge clk_in);
    #1 out_ack = 1'b0;
    check({tag, "/ack_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
    in_opt = '0; in_rs1 = '0; in_rs2 = '0; in_rob_index = '0;
    #12;
    check("reset/valid", 32'(out_valid), 32'd0);
    check("reset/res", out_res, 32'd0);
    check("reset/rob", 32'(out_rob_index), 32'd0);
    check("reset/ready", 32'(in_ready), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    run_op("mul",    OPT_MUL,    32'd7,        32'hFFFFFFFD, 4'd5,  32'hFFFFFFEB, MUL_LAT, 0, 0);
    run_op("mulhu",  OPT_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1,  32'hFFFFFFFE, MUL_LAT, 0, 0);
    run_op("mulh",   OPT_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2,  32'h00000000, MUL_LAT, 0, 0);
    run_op("mulhsu", OPT_MULHSU, 32'hFFFFFFFF, 32'd2,        4'd3,  32'hFFFFFFFF, MUL_LAT, 0, 0);
    run_op("div",    OPT_DIV,    32'hFFFFFFF9, 32'd2,        4'd6,  32'hFFFFFFFD, 33, 0, 0);
    run_op("rem",    OPT_REM,    32'hFFFFFFF9, 32'd2,        4'd7,  32'hFFFFFFFF, 33, 0, 0);
    run_op("divu",   OPT_DIVU,   32'd100,      32'd7,        4'd8,  32'd14,       33, 0, 0);
    run_op("remu",   OPT_REMU,   32'd100,      32'd7,        4'd9,  32'd2,        33, 0, 0);
    run_op("div_ovf",OPT_DIV,    32'h80000000, 32'hFFFFFFFF, 4'd10, 32'h80000000, 1, 0, 0);
    run_op("rem_ovf",OPT_REM,    32'h80000000, 32'hFFFFFFFF, 4'd11, 32'h00000000, 1, 0, 0);
    run_op("divu_z", OPT_DIVU,   32'h12345678, 32'd0,        4'd12, 32'hFFFFFFFF, 1, 0, 0);
    run_op("remu_z", OPT_REMU,   32'd9,        32'd0,        4'd13, 32'd9,        1, 0, 0);
    run_op("bad_opt",6'h01,      32'd5,        32'd6,        4'd14, 32'd0,        1, 0, 0);

    // Flush a divide at its tenth iteration.
    @(negedge clk_in);
    in_valid = 1'b1; in_opt = OPT_DIV; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_rob_index = 4'd3;
    @(posedge clk_in);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk_in);
    @(negedge clk_in);
    flush_in = 1'b1;
    @(posedge clk_in);
    #1 flush_in = 1'b0;
    check("flush/valid", 32'(out_valid), 32'd0);
    check("flush/ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in);
      #1 if (out_valid) seen = 1;
    end
    check("flush/never_valid", 32'(seen), 32'd0);

    // An op offered together with a flush must be ignored.
    @(negedge clk_in);
    in_valid = 1'b1; in_opt = OPT_DIVU; in_rs1 = 32'd9; in_rs2 = 32'd0; in_rob_index = 4'd2;
    flush_in = 1'b1;
    @(posedge clk_in);
    #1 begin in_valid = 1'b0; flush_in = 1'b0; end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1 if (out_valid) seen = 1;
    end
    check("flush_in_idle/no_accept", 32'(seen), 32'd0);
    check("flush_in_idle/ready", 32'(in_ready), 32'd1);

    run_op("divu_hold", OPT_DIVU, 32'd100,      32'd7, 4'd9, 32'd14,       33, 0, 5);
    run_op("div_stall", OPT_DIV,  32'hFFFFFFF9, 32'd2, 4'd4, 32'hFFFFFFFD, 36, 10, 0);

    // Asynchronous reset while a result is pending.
    @(negedge clk_in);
    in_valid = 1'b1; in_opt = OPT_REMU; in_rs1 = 32'd9; in_rs2 = 32'd0; in_rob_index = 4'd15;
    @(posedge clk_in);
    #1 in_valid = 1'b0;
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    check("async_rst/valid", 32'(out_valid), 32'd0);
    check("async_rst/res", out_res, 32'd0);
    check("async_rst/rob", 32'(out_rob_index), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("async_rst/ready_after", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M execution unit for the Tomasulo back end, sitting beside the single-cycle ALU as a second functional unit fed by the reservation station. It accepts one multiply/divide/remainder operation per handshake, tagged with its ROB index. It computes iteratively, or in one cycle for multiplies when fast-mul is compiled in. It holds the result for the CDB arbiter until acknowledged, and drops in-flight work on a misprediction flush.

## Interface
- XLEN, 32, operand/result width (even, ≥ 8)
- ROB_W, 4, ROB index width
- OPT_W, 6, opcode width (shared opt encoding)
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global enable; low freezes all state
- flush_in  input  1  misprediction clear, synchronous
- in_valid  input  1  RS issues an op
- in_ready  output  1  unit can accept; combinational = (state==IDLE) && rdy_in && rst_n_in
- in_opt  input  OPT_W  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- in_rs1, in_rs2  input  XLEN  operands
- in_rob_index  input  ROB_W  destination tag
- out_valid  output  1  result pending for CDB
- out_res  output  XLEN  result
- out_rob_index  output  ROB_W  tag of result
- out_ack  input  1  CDB grant; consumes result

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset → IDLE; all outputs registered and 0 (out_valid=0, out_res=0, out_rob_index=0).
- IDLE: on in_valid && in_ready, latch the operands, opt, and tag.
  - Fast-mul build, MUL*: go to DONE.
  - Otherwise MUL*: go to MUL.
  - Div-by-zero or signed overflow: go to DONE with the result computed directly.
  - Other DIV*/REM*: go to DIV.
  - Unsupported opt: go to DONE with result 0.
- Signed handling: latch |rs1| and |rs2| per signedness (MULHSU: rs1 signed, rs2 unsigned). Run an unsigned core, then negate the result when the signs differ. For REM, the remainder takes the sign of the dividend.
- MUL: shift-add, one bit per cycle, 2·XLEN-bit accumulator, XLEN iterations, then one fix-up cycle → DONE. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DIV: restoring radix-2, XLEN iterations, then one fix-up cycle → DONE.
- Special cases:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - DIV with rs1 = 2^(XLEN-1) and rs2 = −1: quotient = rs1; REM = 0.
- DONE: out_valid=1; out_res and out_rob_index stable. On out_ack → IDLE, and out_valid falls after that edge.
- Flush: the highest-priority event, honoured even when rdy_in=0. At the next edge state → IDLE and out_valid → 0. An input offered in the same cycle is not accepted, because in_ready is ignored under flush.
- rdy_in=0 without flush: state, counter and outputs hold; out_ack is ignored.

## Timing
- Accepting edge = k.
- Fast mul, special-case div, or unsupported opt: out_valid high after edge k+1.
- Iterative mul/div: iterations on edges k+1..k+XLEN, fix-up at k+XLEN+1; out_valid high after edge k+XLEN+1.
- Each cycle with rdy_in=0 extends latency by exactly one cycle.
- Throughput: ack at edge a → IDLE; the next accept is at edge a+1 at the earliest. No overlap of ops.
- A reset asserted mid-operation immediately forces IDLE and zeroed outputs, independent of the clock.

## Configuration
- MULDIV_FAST_MUL_EN defined: MUL* uses a single-cycle (XLEN+1)×(XLEN+1) signed multiplier registered into DONE; latency 1.
- MULDIV_FAST_MUL_EN undefined: MUL* uses the shift-add path; latency XLEN+1.
- Division is identical in both builds.

## Structure
- The shared utils header gains opt codes MUL..REMU (distinct from existing ALU codes) and the FSM state localparams.
- Sub-module muldiv_sign_adjust (combinational): operand absolute values and the final result negation, instantiated twice (operands, result).

## Test plan
- XLEN=32, MUL rs1=7, rs2=−3, tag 5 → out_res=0xFFFFFFEB, out_rob_index=5. out_valid rises after k+1 (fast) or k+33 (iterative).
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0; MULHSU rs1=−1, rs2=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each valid after k+33.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. DIVU x/0 → 0xFFFFFFFF and REMU 9/0 → 9. All of these are valid after k+1.
- DIV in flight, flush_in at iteration 10 → IDLE next edge, out_valid never rises. in_ready high the following cycle; a new op is accepted normally.
- out_ack withheld 5 cycles → result and tag held stable, in_ready=0. Then rdy_in=0 for 3 cycles mid-DIV → completion delayed exactly 3 cycles.
